// File: rtl/pc_branch_unit.sv
`timescale 1ns/1ps
`default_nettype none
// pc_branch_unit -- fetch PC register, B/BL redirect, younger-slot flush and BL link write. Rev 1.0
module pc_branch_unit #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int          FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        branch_valid,
  input  logic        cond_pass,
  input  logic        branch_link,
  input  logic [31:0] ex_pc,
  input  logic [31:0] branch_offset,
  output logic [31:0] pc,
  output logic        flush,
  output logic        branch_taken,
  output logic        lr_we,
  output logic [31:0] lr_data
);

  localparam logic [2:0] FLUSH_INIT = 3'(FLUSH_CYCLES);

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_t;

  state_t      state;
  logic [2:0]  count;
  logic        accept;
  logic [31:0] target;

  assign accept = (state == RUN) && branch_valid && cond_pass;
  // Target is relative to the executing instruction's PC+8 and always word aligned.
  assign target = (ex_pc + 32'd8 + branch_offset) & 32'hFFFF_FFFC;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= RUN;
      count        <= 3'd0;
      pc           <= RESET_PC;
      flush        <= 1'b0;
      branch_taken <= 1'b0;
      lr_we        <= 1'b0;
      lr_data      <= 32'd0;
    end else begin
      branch_taken <= 1'b0;
      lr_we        <= 1'b0;
      case (state)
        RUN: begin
          if (accept) begin
            pc           <= target;
            branch_taken <= 1'b1;
            flush        <= 1'b1;
            count        <= FLUSH_INIT;
            state        <= FLUSH;
            if (branch_link) begin
              lr_we   <= 1'b1;
              lr_data <= ex_pc + 32'd4;
            end
          end else if (!stall) begin
            pc <= pc + 32'd4;
          end
        end
        FLUSH: begin
          // Only advancing cycles retire a killed slot; stalls stretch the window.
          if (!stall) begin
            pc <= pc + 32'd4;
            if (count == 3'd1) begin
              count <= 3'd0;
              flush <= 1'b0;
              state <= RUN;
            end else begin
              count <= count - 3'd1;
            end
          end
        end
        default: begin
          state <= RUN;
          flush <= 1'b0;
          count <= 3'd0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pc_branch_unit.sv
`timescale 1ns/1ps
`default_nettype none
// tb_pc_branch_unit -- directed test-plan steps followed by random traffic against a rule-level model.
module tb_pc_branch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          FLUSH_CYCLES = 2;

  logic        clk = 1'b0;
  logic        rst_n, stall, branch_valid, cond_pass, branch_link;
  logic [31:0] ex_pc, branch_offset;
  logic [31:0] pc, lr_data;
  logic        flush, branch_taken, lr_we;

  int checks = 0;
  int errors = 0;

  // Reference state: PC, remaining killed slots, last pulses and link value.
  logic [31:0] m_pc;
  int          m_left;
  logic        m_bt, m_lrwe;
  logic [31:0] m_lrd;

  pc_branch_unit #(.RESET_PC(RESET_PC), .FLUSH_CYCLES(FLUSH_CYCLES)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .branch_valid(branch_valid),
    .cond_pass(cond_pass), .branch_link(branch_link), .ex_pc(ex_pc),
    .branch_offset(branch_offset), .pc(pc), .flush(flush),
    .branch_taken(branch_taken), .lr_we(lr_we), .lr_data(lr_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // Advance one edge, apply the rules to the model, compare every output.
  task automatic tick();
    @(posedge clk);
    if (!rst_n) begin
      m_pc = RESET_PC; m_left = 0; m_bt = 0; m_lrwe = 0; m_lrd = 0;
    end else begin
      m_bt = 0; m_lrwe = 0;
      if (m_left == 0 && branch_valid && cond_pass) begin
        m_pc   = {ex_pc + 32'd8 + branch_offset} & ~32'd3;
        m_bt   = 1;
        m_left = FLUSH_CYCLES;
        if (branch_link) begin
          m_lrwe = 1;
          m_lrd  = ex_pc + 32'd4;
        end
      end else if (!stall) begin
        m_pc = m_pc + 32'd4;
        if (m_left > 0) m_left--;
      end
    end
    #1;
    chk("model_pc", pc, m_pc);
    chk("model_flush", {31'd0, flush}, {31'd0, (m_left > 0)});
    chk("model_branch_taken", {31'd0, branch_taken}, {31'd0, m_bt});
    chk("model_lr_we", {31'd0, lr_we}, {31'd0, m_lrwe});
    chk("model_lr_data", lr_data, m_lrd);
  endtask

  task automatic br(input logic [31:0] epc, input logic [31:0] off, input logic lnk);
    branch_valid = 1; cond_pass = 1; branch_link = lnk; ex_pc = epc; branch_offset = off;
  endtask

  task automatic idle();
    branch_valid = 0; cond_pass = 0; branch_link = 0;
  endtask

  initial begin
    int flush_hi;
    m_pc = 0; m_left = 0; m_bt = 0; m_lrwe = 0; m_lrd = 0;
    rst_n = 0; stall = 0; idle(); ex_pc = 0; branch_offset = 0;
    #2;

    // Reset and free-running increment
    tick(); tick();
    chk("reset_pc", pc, 32'h0);
    chk("reset_strobes", {29'd0, flush, branch_taken, lr_we}, 32'd0);
    rst_n = 1;
    tick(); tick(); tick();
    chk("run_pc_after3", pc, 32'hC);

    // Backward B
    br(32'h100, 32'hFFFF_FFF0, 0);
    tick();
    chk("bwd_pc", pc, 32'hF8);
    chk("bwd_taken", {31'd0, branch_taken}, 32'd1);
    chk("bwd_lr_we", {31'd0, lr_we}, 32'd0);
    chk("bwd_flush1", {31'd0, flush}, 32'd1);
    idle();
    tick();
    chk("bwd_pc2", pc, 32'hFC);
    chk("bwd_flush2", {31'd0, flush}, 32'd1);
    tick();
    chk("bwd_pc3", pc, 32'h100);
    chk("bwd_flush_off", {31'd0, flush}, 32'd0);

    // BL
    br(32'h2000, 32'h400, 1);
    tick();
    chk("bl_pc", pc, 32'h2408);
    chk("bl_lr_we", {31'd0, lr_we}, 32'd1);
    chk("bl_lr_data", lr_data, 32'h2004);
    idle();
    tick();
    chk("bl_lr_we_pulse", {31'd0, lr_we}, 32'd0);
    chk("bl_lr_data_hold", lr_data, 32'h2004);
    tick();

    // Condition fail, then branches presented during and at the end of flush
    branch_valid = 1; cond_pass = 0; ex_pc = 32'h7000; branch_offset = 32'h40;
    tick();
    chk("condfail_pc", pc, 32'h2414);
    chk("condfail_taken", {31'd0, branch_taken}, 32'd0);
    br(32'h3000, 32'h0, 0);
    tick();
    chk("b3_pc", pc, 32'h3008);
    br(32'h5000, 32'h0, 0);
    tick();
    chk("inflush_pc", pc, 32'h300C);
    chk("inflush_taken", {31'd0, branch_taken}, 32'd0);
    tick();
    chk("lastslot_pc", pc, 32'h3010);
    chk("lastslot_taken", {31'd0, branch_taken}, 32'd0);
    tick();
    chk("resume_pc", pc, 32'h5008);
    chk("resume_taken", {31'd0, branch_taken}, 32'd1);
    idle();
    tick(); tick();

    // Wrap-around target, then stalls inside the flush window
    br(32'hFFFF_FFF8, 32'h10, 0);
    tick();
    chk("wrap_pc", pc, 32'h10);
    idle();
    flush_hi = 1;
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_pc_hold", pc, 32'h10);
      if (flush) flush_hi++;
    end
    stall = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (flush) flush_hi++;
    end
    chk("stall_flush_len", flush_hi, 32'd5);
    chk("stall_pc_after", pc, 32'h1C);

    // Reset one cycle after accept
    br(32'h800, 32'h100, 1);
    tick();
    idle();
    rst_n = 0;
    tick();
    chk("midflush_rst_pc", pc, RESET_PC);
    chk("midflush_rst_flush", {31'd0, flush}, 32'd0);
    rst_n = 1;
    br(32'h40, 32'h0, 0);
    tick();
    chk("post_rst_accept_pc", pc, 32'h48);
    chk("post_rst_accept_taken", {31'd0, branch_taken}, 32'd1);
    idle();

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      rst_n         = ($urandom_range(0, 63) != 0);
      stall         = ($urandom_range(0, 3) == 0);
      branch_valid  = ($urandom_range(0, 1) == 1);
      cond_pass     = ($urandom_range(0, 3) != 0);
      branch_link   = ($urandom_range(0, 1) == 1);
      ex_pc         = $urandom & 32'hFFFF_FFFC;
      branch_offset = ($urandom_range(0, 3) == 0) ? ($urandom << 2) :
                      (32'($signed($urandom_range(0, 512)) - 256) << 2);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
